// File: rtl/instr_pack_loader_pkg.sv
// Shared types and constants for the RV32I instruction pack/loader.
package instr_pack_loader_pkg;

  typedef enum logic [1:0] {
    FMT_I = 2'b00,
    FMT_S = 2'b01,
    FMT_B = 2'b10,
    FMT_R = 2'b11
  } fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_e;

  typedef struct packed {
    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  // True when bits [31:lsb] are all copies of bit lsb, i.e. v fits in lsb+1 signed bits.
  function automatic logic sext_fits(input logic [31:0] v, input int lsb);
    logic ok;
    ok = 1'b1;
    for (int i = lsb; i < 32; i++)
      if (v[i] != v[lsb]) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/instr_pack_loader_if.sv
// Field-bundle input handshake plus instruction-memory write port.
interface instr_pack_loader_if #(parameter int ADDR_W = 32);
  import instr_pack_loader_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  fmt_e              in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ready;

  modport master (
    output in_valid, in_last, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_last, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/instr_pack_loader_imm_pack.sv
// Combinational packer: scatters immediate bits into the I/S/B/R layouts and flags out-of-range immediates.
module imm_pack
  import instr_pack_loader_pkg::*;
(
  input  fields_t     f,
  output logic [31:0] word,
  output logic        range_err
);

  always_comb begin
    word      = '0;
    range_err = 1'b0;
    case (f.fmt)
      FMT_I: begin
        word      = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
        range_err = !sext_fits(f.imm, 11);
      end
      FMT_S: begin
        word      = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
        range_err = !sext_fits(f.imm, 11);
      end
      FMT_B: begin
        word      = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                     f.imm[4:1], f.imm[11], f.opcode};
        // 13-bit signed and even: imm[0] has no slot in the encoding
        range_err = !sext_fits(f.imm, 12) || f.imm[0];
      end
      FMT_R: begin
        word      = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
      end
      default: begin
        word      = '0;
        range_err = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_pack_loader.sv
// Program loader: packs field bundles into RV32I words and streams them into imem from base_addr.
module instr_pack_loader
  import instr_pack_loader_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] NOP_WORD = instr_pack_loader_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  instr_pack_loader_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_index,
  output logic [ADDR_W-1:0] count
);

  state_e            state, state_nx;
  fields_t           fin;
  logic [31:0]       pk_word;
  logic              pk_err;
  logic              hold_valid, hold_last, hold_bad, last_seen;
  logic [31:0]       hold_word;
  logic [ADDR_W-1:0] wr_ptr;
  logic              accept, wr_done, arm, rdy;

  assign fin = '{fmt: bus.in_fmt, opcode: bus.in_opcode, rd: bus.in_rd,
                 rs1: bus.in_rs1, rs2: bus.in_rs2, funct3: bus.in_funct3,
                 funct7: bus.in_funct7, imm: bus.in_imm};

  imm_pack u_pack (.f(fin), .word(pk_word), .range_err(pk_err));

  assign wr_done = hold_valid && bus.imem_ready;
  assign accept  = bus.in_valid && rdy;
  assign arm     = start && (state != ST_LOAD);

  assign bus.in_ready   = rdy;
  assign bus.imem_we    = hold_valid;
  assign bus.imem_addr  = wr_ptr;
  assign bus.imem_wdata = hold_word;

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    rdy      = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nx = ST_LOAD;
      ST_LOAD: begin
        busy = 1'b1;
        // the holding slot frees up in the same cycle its word is written
        rdy  = !last_seen && (!hold_valid || wr_done);
        if (wr_done && hold_last) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_nx = ST_LOAD;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
      hold_bad   <= 1'b0;
      hold_word  <= '0;
      last_seen  <= 1'b0;
      wr_ptr     <= '0;
      count      <= '0;
      err        <= 1'b0;
      err_index  <= '0;
    end else begin
      state <= state_nx;
      if (arm) begin
        wr_ptr    <= base_addr;
        count     <= '0;
        err       <= 1'b0;
        err_index <= '0;
        last_seen <= 1'b0;
      end else begin
        if (accept && bus.in_last) last_seen <= 1'b1;
        if (wr_done) begin
          wr_ptr <= wr_ptr + ADDR_W'(4);
          count  <= count + 1'b1;
          if (hold_bad && !err) begin
            err       <= 1'b1;
            err_index <= count;
          end
        end
      end
      if (accept) begin
        hold_valid <= 1'b1;
        hold_word  <= pk_err ? NOP_WORD : pk_word;
        hold_last  <= bus.in_last;
        hold_bad   <= pk_err;
      end else if (wr_done) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/instr_pack_loader.md
Name: instr_pack_loader

Overview:
- Inverse of the core's immediate extender: packs decoded fields (opcode, registers, funct, 32-bit immediate) into a 32-bit RV32I instruction word.
- Scatters immediate bits into I/S/B/R layouts and streams the packed words into instruction memory through a write port.
- Used as the debug/bench program loader ahead of the pipelined core: valid/ready input, one-entry holding stage, sequential address counter, sticky range-error reporting.

Parameters:
- ADDR_W, 32: byte-address width of the imem write port.
- NOP_WORD, 32'h00000013: word written in place of an instruction whose immediate is out of range.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  pulse: arm a load session at base_addr
- base_addr  in  ADDR_W  first write address, sampled on start
- in_valid  in  1  input field bundle valid
- in_ready  out  1  block accepts the bundle this cycle
- in_last  in  1  bundle is the final instruction of the session
- in_fmt  in  2  00 I, 01 S, 10 B, 11 R (immediate ignored)
- in_opcode  in  7  opcode[6:0]
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7, R only
- in_imm  in  32  signed immediate
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_W  write byte address
- imem_wdata  out  32  packed word
- imem_ready  in  1  memory accepts the write this cycle
- busy  out  1  session active (LOAD)
- done  out  1  session completed
- err  out  1  sticky: at least one immediate was out of range
- err_index  out  ADDR_W  instruction index of the first error
- count  out  ADDR_W  instructions written this session

Behaviour:
- Reset: state IDLE. in_ready, imem_we, busy, done, err = 0. imem_addr, imem_wdata, err_index, count = 0. Holding register invalid.
- FSM states:
  - IDLE --start--> LOAD: wr_ptr=base_addr; count, err, err_index cleared.
  - LOAD --write of the in_last word completes--> DONE.
  - DONE --start--> LOAD, with the same loading actions as from IDLE.
  - start in LOAD is ignored.
- in_ready = (state==LOAD) && !last_seen && (!hold_valid || (imem_we && imem_ready)).
- Accepted bundle is packed combinationally and registered into the holding stage.
- imem_we asserts the next cycle and holds with stable addr/wdata until imem_ready. Latency: accept to first imem_we = 1 cycle.
- Throughput: one word per cycle with imem_ready high.
- Packing:
  - I: {imm[11:0],rs1,f3,rd,op}
  - S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}
  - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
  - R: {f7,rs2,rs1,f3,rd,op}
- Range rule:
  - I/S: imm must be in [-2048, 2047].
  - B: imm must be in [-4096, 4094] with imm[0]=0.
  - On violation: write NOP_WORD to the same slot, so addresses stay aligned.
  - On the first violation: set err and latch err_index=count.
- On each completed write: wr_ptr += 4, wrapping mod 2^ADDR_W; count += 1, wrapping.
- done is a level, high in DONE only. busy = (state==LOAD).
- Reset mid-LOAD: the holding word is dropped, no further write occurs, and all outputs return to reset values on the next edge.

Decomposition:
- Shared package: fmt enum (FMT_I, FMT_S, FMT_B, FMT_R), the OPC_* opcode constants, NOP_WORD, and the FSM state enum.
- One combinational sub-module, imm_pack: fmt, fields and imm in; word and range_err out.
- FSM, holding stage and counters stay in the top module.

Test Plan:
- start base=0x100; I addi x1,x0,imm=0xFFFFFFFF -> imem_we one cycle later, addr 0x100, wdata 0xFFF00093, count=1.
- S: op 0x23, f3=2, rs1=1, rs2=2, imm=8 -> wdata 0x0020A423. B: op 0x63, rs1=rs2=0, imm=-4 -> 0xFE000EE3. The core's extender must recover imm from both words.
- I with imm=2048, as the 3rd instruction -> NOP 0x00000013 written at base+8; err=1, err_index=2. A later bad imm leaves err_index at 2.
- imem_ready low 3 cycles while in_valid is held -> in_ready=0, addr/wdata stable, no bundle lost or duplicated, order preserved.
- 4-word burst with in_last on the 4th -> done=1, busy=0, in_ready=0. New start with base=0x0 -> count=0, err=0, first write at 0x0.
- reset asserted while holding is valid and imem_ready=0 -> no write. Next cycle: all outputs 0, state IDLE. With ADDR_W=4 and base=0xC, the second write wraps to addr 0x0.
